fetch_pair_buffer: RTL and testbench

Instruction prefetch stage that sits directly upstream of the dual-issue decode/execute stage. It reads 64-bit instruction pairs from the synchronous instruction RAM and queues them in a small FIFO. It delivers one pair per cycle over a valid/ready handshake. On a taken branch, jal or jalr redirect it flushes the queue, discards any in-flight read, and restarts fetching at the redirect target.

---
 rtl/fetch_pair_buffer.sv | 111 +++++++++++
 tb/tb_fetch_pair_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_buffer.sv
// Purpose : instruction prefetch; reads 64-bit pairs from sync RAM and queues them for dual-issue decode.
// Latency : read issued in cycle T is pushed at end of T+1, so the pair is valid in T+2 (no bypass).
// Backpr. : valid/ready at the output; reads are issued only while a FIFO slot is reserved for the response.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_en, mem_addr           instruction RAM read request (mem_addr always even)
//   mem_rdata                  pair read data, one cycle after mem_en ([63:32] = word mem_addr)
//   redirect_valid/_pc         taken branch/jal/jalr: flush and restart at redirect_pc
//   pair_valid/_ready          head-of-queue handshake towards execute
//   pair_instr, pair_pc        head pair (slot 1 in [63:32], older) and its even word address
module fetch_pair_buffer #(
    parameter int          ADDR_W = 12,
    parameter int          DEPTH  = 4,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [63:0]       pair_instr,
    output logic [ADDR_W-1:0] pair_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [OW-1:0]     r_occ;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_odd_fix;
    logic [63:0]       r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];

    logic [ADDR_W-1:0] w_tgt;
    logic              w_pop;
    logic              w_push;
    logic [OW:0]       w_used;
    logic [63:0]       w_push_dat;

    assign w_tgt = {redirect_pc[ADDR_W-1:1], 1'b0};

    // A redirect cycle hides the stale head so execute cannot consume it.
    assign pair_valid = rst_n & ~redirect_valid & (r_occ != '0);
    assign pair_instr = pair_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign pair_pc    = pair_valid ? r_fifo_pc[r_rd_ptr]    : '0;

    assign w_pop  = pair_valid & pair_ready;
    assign w_push = r_inflight & ~redirect_valid;

    // Credits: queued + in-flight, less the slot a same-cycle pop frees.
    // Pop implies r_occ > 0, so this never underflows.
    assign w_used = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight} - {{OW{1'b0}}, w_pop};

    assign mem_en   = rst_n & (redirect_valid | (w_used < (OW+1)'(DEPTH)));
    assign mem_addr = (rst_n & redirect_valid) ? w_tgt : r_fetch_pc;

    // An odd redirect target must not execute the even word preceding it.
    assign w_push_dat = r_odd_fix ? {NOP, mem_rdata[31:0]} : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= '0;
            r_occ         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_odd_fix     <= 1'b0;
        end else if (redirect_valid) begin
            r_occ         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fetch_pc    <= w_tgt + ADDR_W'(2);
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_tgt;
            r_odd_fix     <= redirect_pc[0];
        end else begin
            r_occ      <= r_occ + OW'(w_push) - OW'(w_pop);
            r_inflight <= mem_en;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_odd_fix <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (mem_en) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(2);
            end
        end
    end

    // Payload storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_fifo_instr[r_wr_ptr] <= w_push_dat;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pair_buffer.sv
module tb_fetch_pair_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        pair_valid;
    logic        pair_ready = 1'b0;
    logic [63:0] pair_instr;
    logic [11:0] pair_pc;

    int n_chk = 0;
    int n_fail = 0;

    fetch_pair_buffer #(.ADDR_W(12), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_instr(pair_instr), .pair_pc(pair_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [11:0] a);
        return {20'hABCDE, a};
    endfunction

    // Synchronous RAM: data one cycle after the enable.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= {word(mem_addr), word(mem_addr + 12'd1)};
    end

    function automatic logic [63:0] pair_of(input logic [11:0] pc, input bit fix);
        logic [11:0] pn;
        pn = pc + 12'd1;
        return {fix ? NOP : word(pc), word(pn)};
    endfunction

    // ---------------- reference model (transaction queues) ----------------
    logic [11:0] q_pc[$];
    bit          q_fix[$];
    bit          m_fv = 0;
    logic [11:0] m_fpc = '0;
    bit          m_ffix = 0;
    logic [11:0] m_pc = '0;
    bit          m_pending = 0;

    bit          e_rst, e_rv, e_pop, e_en, e_pv;
    logic [11:0] e_rpc, e_addr, e_ppc;
    logic [63:0] e_instr;
    logic [89:0] exp_vec;

    function automatic logic [89:0] obs();
        return {mem_en, mem_en ? mem_addr : 12'h0, pair_valid, pair_pc, pair_instr};
    endfunction

    task automatic model_eval();
        int used;
        e_rst = rst_n; e_rv = redirect_valid; e_rpc = redirect_pc;
        e_pop = 0; e_en = 0; e_pv = 0;
        if (rst_n) begin
            e_pv  = (q_pc.size() > 0) && !redirect_valid;
            e_pop = e_pv && pair_ready;
            used  = q_pc.size() + (m_fv ? 1 : 0) - (e_pop ? 1 : 0);
            e_en  = redirect_valid || (used < DEPTH);
        end
        e_addr  = redirect_valid ? {redirect_pc[11:1], 1'b0} : m_pc;
        e_ppc   = e_pv ? q_pc[0] : 12'h0;
        e_instr = e_pv ? pair_of(q_pc[0], q_fix[0]) : 64'h0;
        exp_vec = {e_en, e_en ? e_addr : 12'h0, e_pv, e_ppc, e_instr};
    endtask

    task automatic model_commit();
        logic [11:0] al;
        al = {e_rpc[11:1], 1'b0};
        if (!e_rst) begin
            q_pc.delete(); q_fix.delete();
            m_fv = 0; m_ffix = 0; m_pc = 12'h0;
        end else if (e_rv) begin
            q_pc.delete(); q_fix.delete();
            m_fv = 1; m_fpc = al; m_ffix = e_rpc[0]; m_pc = al + 12'd2;
        end else begin
            if (e_pop) begin void'(q_pc.pop_front()); void'(q_fix.pop_front()); end
            if (m_fv) begin q_pc.push_back(m_fpc); q_fix.push_back(m_ffix); end
            if (e_en) begin m_fv = 1; m_fpc = m_pc; m_ffix = 0; m_pc = m_pc + 12'd2; end
            else m_fv = 0;
        end
    endtask

    // One cycle: fold in the previous edge, apply inputs, predict outputs.
    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [11:0] rpc);
        @(negedge clk);
        if (m_pending) model_commit();
        rst_n = rst; pair_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        model_eval();
        m_pending = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 12'h0);
            n_chk++;
            if (mem_en !== 1'b0 || pair_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_gate cyc%0d got en=%b pv=%b exp 0/0", i, mem_en, pair_valid);
            end
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (mem_en !== 1'b1 || mem_addr !== 12'h000) begin
            n_fail++; $display("FAIL reset_c0 got en=%b addr=%h exp 1/000", mem_en, mem_addr);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_c1 got pv=%b exp 0", pair_valid);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h000 || pair_instr !== pair_of(12'h000, 0)) begin
            n_fail++; $display("FAIL reset_c2 got pv=%b pc=%h d=%h exp 1/000/%h",
                               pair_valid, pair_pc, pair_instr, pair_of(12'h000, 0));
        end
    endtask

    task automatic test_stream();
        logic [11:0] want;
        want = 12'h002;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 12'h0);
            n_chk++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL stream cyc%0d got %h exp %h", i, obs(), exp_vec);
            end
            n_chk++;
            if (pair_valid !== 1'b1 || pair_pc !== want) begin
                n_fail++; $display("FAIL stream_seq cyc%0d got pv=%b pc=%h exp 1/%h", i, pair_valid, pair_pc, want);
            end
            want = want + 12'd2;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 12'h0);
            n_chk++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL bp_hold cyc%0d got %h exp %h", i, obs(), exp_vec);
            end
        end
        n_chk++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got en=%b exp 0", mem_en);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (mem_en !== 1'b1 || pair_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume got en=%b pv=%b exp 1/1", mem_en, pair_valid);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 12'h0);
            n_chk++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL bp_drain cyc%0d got %h exp %h", i, obs(), exp_vec);
            end
        end
    endtask

    task automatic test_even_redirect();
        step(1, 0, 0, 12'h0);
        step(1, 0, 0, 12'h0);
        step(1, 1, 1, 12'h040);
        n_chk++;
        if (pair_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 12'h040) begin
            n_fail++; $display("FAIL redir_t got pv=%b en=%b addr=%h exp 0/1/040", pair_valid, mem_en, mem_addr);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_t1 got pv=%b exp 0", pair_valid);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h040 || pair_instr !== pair_of(12'h040, 0)) begin
            n_fail++; $display("FAIL redir_t2 got pv=%b pc=%h d=%h exp 1/040", pair_valid, pair_pc, pair_instr);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h042) begin
            n_fail++; $display("FAIL redir_t3 got pv=%b pc=%h exp 1/042", pair_valid, pair_pc);
        end
    endtask

    task automatic test_odd_redirect();
        step(1, 1, 1, 12'h100);
        step(1, 1, 1, 12'h051);
        n_chk++;
        if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL odd_t got %h exp %h", obs(), exp_vec);
        end
        step(1, 1, 0, 12'h0);
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h050 || pair_instr !== {NOP, word(12'h051)}) begin
            n_fail++; $display("FAIL odd_first got pv=%b pc=%h d=%h exp 1/050/%h%h",
                               pair_valid, pair_pc, pair_instr, NOP, word(12'h051));
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h052 || pair_instr !== pair_of(12'h052, 0)) begin
            n_fail++; $display("FAIL odd_next got pv=%b pc=%h d=%h exp 1/052", pair_valid, pair_pc, pair_instr);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] pcs [3];
        pcs[0] = 12'hFFE; pcs[1] = 12'h000; pcs[2] = 12'h002;
        step(1, 1, 1, 12'hFFE);
        step(1, 1, 0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 12'h0);
            n_chk++;
            if (pair_valid !== 1'b1 || pair_pc !== pcs[i] || pair_instr !== pair_of(pcs[i], 0)) begin
                n_fail++; $display("FAIL wrap%0d got pv=%b pc=%h d=%h exp 1/%h", i, pair_valid, pair_pc, pair_instr, pcs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 12'h0);
        step(0, 0, 1, 12'h123);
        n_chk++;
        if (mem_en !== 1'b0 || pair_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_gate got en=%b pv=%b exp 0/0", mem_en, pair_valid);
        end
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (mem_en !== 1'b1 || mem_addr !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_c0 got en=%b addr=%h exp 1/000", mem_en, mem_addr);
        end
        step(1, 1, 0, 12'h0);
        step(1, 1, 0, 12'h0);
        n_chk++;
        if (pair_valid !== 1'b1 || pair_pc !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_c2 got pv=%b pc=%h exp 1/000", pair_valid, pair_pc);
        end
    endtask

    task automatic test_random();
        logic rdy, rv, rst;
        logic [11:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = 12'($urandom);
            step(rst, rdy, rv, rpc);
            n_chk++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL random cyc%0d got %h exp %h", i, obs(), exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_even_redirect();
        test_odd_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
